// File: rtl/ser2par_pkg.sv
// Shared definitions for the serial-to-parallel word collector.
// State S_PAR is used only when SER2PAR_PARITY_EN is defined.
package ser2par_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } state_e;

  localparam int SER2PAR_DW_DEFAULT = 8;

endpackage

// File: rtl/ser2par_outreg.sv
// Single-entry output holding register with valid/ready, sticky overflow and
// optional parity-error flag (SER2PAR_PARITY_EN).
module ser2par_outreg
  import ser2par_pkg::*;
#(
  parameter int DW = SER2PAR_DW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_word,
`ifdef SER2PAR_PARITY_EN
  input  logic          i_perr,
  output logic          o_perr,
`endif
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_overflow
);

  // Handshake: a word transfers on any rising edge where o_valid && i_ready;
  // o_data is held stable while o_valid=1 and no transfer has occurred.
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
`ifdef SER2PAR_PARITY_EN
  logic          perr_q, perr_d;
`endif

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
`ifdef SER2PAR_PARITY_EN
    perr_d     = perr_q;
`endif
    if (i_load) begin
      // The slot frees up this edge if it is empty or being accepted now.
      if (!valid_q || i_ready) begin
        data_d  = i_word;
        valid_d = 1'b1;
`ifdef SER2PAR_PARITY_EN
        perr_d  = i_perr;
`endif
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SER2PAR_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
`ifdef SER2PAR_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_overflow = overflow_q;
`ifdef SER2PAR_PARITY_EN
  assign o_perr     = perr_q;
`endif

endmodule

// File: rtl/ser2par_collector.sv
// Packs strobed serial bits into DW-bit words; FSM, bit counter and shifter.
// Optional trailing even-parity bit when SER2PAR_PARITY_EN is defined.
module ser2par_collector
  import ser2par_pkg::*;
#(
  parameter int DW        = SER2PAR_DW_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_d,
  input  logic          i_en,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_busy,
  output logic          o_overflow,
`ifdef SER2PAR_PARITY_EN
  output logic          o_perr,
`endif
  output logic [1:0]    o_dbg_state
);

  localparam int CW = $clog2(DW + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] shift_nx;
  logic          word_done;
  logic [DW-1:0] word;
`ifdef SER2PAR_PARITY_EN
  logic          word_perr;
`endif

  always_comb begin
    shift_nx  = MSB_FIRST ? {shift_q[DW-2:0], i_d} : {i_d, shift_q[DW-1:1]};
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    word      = shift_nx;
`ifdef SER2PAR_PARITY_EN
    word_perr = (^shift_q) ^ i_d;
`endif
    if (i_en) begin
      case (state_q)
        S_IDLE: begin
          shift_d = shift_nx;
          cnt_d   = CW'(1);
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          shift_d = shift_nx;
          if (cnt_q == CW'(DW - 1)) begin
            cnt_d = '0;
`ifdef SER2PAR_PARITY_EN
            state_d = S_PAR;
`else
            state_d   = S_IDLE;
            word_done = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SER2PAR_PARITY_EN
        // Shifter already holds the full word; this strobe carries parity.
        S_PAR: begin
          word      = shift_q;
          word_done = 1'b1;
          state_d   = S_IDLE;
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == S_SHIFT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
    end
  end

  ser2par_outreg #(.DW(DW)) u_outreg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (word_done),
    .i_word     (word),
`ifdef SER2PAR_PARITY_EN
    .i_perr     (word_perr),
    .o_perr     (o_perr),
`endif
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_overflow (o_overflow)
  );

  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ser2par_collector.sv
// Directed bench for ser2par_collector: one MSB-first and one LSB-first
// instance share the same serial stimulus.
module tb_ser2par_collector;

  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_d = 1'b0;
  logic          i_en = 1'b0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] data_m, data_l;
  logic          valid_m, valid_l;
  logic          busy_m, busy_l;
  logic          ovf_m, ovf_l;
  logic [1:0]    st_m, st_l;
`ifdef SER2PAR_PARITY_EN
  logic          perr_m, perr_l;
`endif

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  ser2par_collector #(.DW(DW), .MSB_FIRST(1'b1)) dut_m (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .i_en(i_en),
    .o_data(data_m), .o_valid(valid_m), .i_ready(i_ready),
    .o_busy(busy_m), .o_overflow(ovf_m),
`ifdef SER2PAR_PARITY_EN
    .o_perr(perr_m),
`endif
    .o_dbg_state(st_m)
  );

  ser2par_collector #(.DW(DW), .MSB_FIRST(1'b0)) dut_l (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .i_en(i_en),
    .o_data(data_l), .o_valid(valid_l), .i_ready(i_ready),
    .o_busy(busy_l), .o_overflow(ovf_l),
`ifdef SER2PAR_PARITY_EN
    .o_perr(perr_l),
`endif
    .o_dbg_state(st_l)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_en  = 1'b0;
    tick();
    i_rst = 1'b0;
  endtask

  // Sends w MSB-first on the wire (plus parity bit if enabled); leaves i_en=1.
  task automatic send_word(input logic [DW-1:0] w, input int gap_max,
                           input logic par_flip, input logic ready_last);
    int g;
    for (int i = 0; i < DW; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        i_en = 1'b0;
        repeat (g) begin
          i_d = 1'($urandom);
          tick();
        end
      end
      i_en = 1'b1;
      i_d  = w[DW-1-i];
`ifndef SER2PAR_PARITY_EN
      if (ready_last && i == DW - 1) i_ready = 1'b1;
`endif
      tick();
    end
`ifdef SER2PAR_PARITY_EN
    i_en = 1'b1;
    i_d  = (^w) ^ par_flip;
    if (ready_last) i_ready = 1'b1;
    tick();
`else
    if (par_flip) i_d = i_d;
`endif
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b0; i_ready = 1'b0;
    repeat (2) tick();
    i_rst = 1'b0;
    checks++; if (data_m !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_m); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_m); end
    checks++; if (st_m !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st_m); end
`ifdef SER2PAR_PARITY_EN
    checks++; if (perr_m !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", perr_m); end
`endif
  endtask

  task automatic test_bit_order();
    i_ready = 1'b1;
    send_word(8'hB2, 0, 1'b0, 1'b0);
    i_en = 1'b0;
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL order_valid got=%b exp=1", valid_m); end
    checks++; if (data_m !== 8'hB2) begin errors++; $display("FAIL order_msb got=%h exp=b2", data_m); end
    checks++; if (data_l !== 8'h4D) begin errors++; $display("FAIL order_lsb got=%h exp=4d", data_l); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL order_busy got=%b exp=0", busy_m); end
    tick();
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL order_valid_drop got=%b exp=0", valid_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL order_ovf got=%b exp=0", ovf_m); end
  endtask

  task automatic test_overflow();
    do_reset();
    i_ready = 1'b0;
    send_word(8'hA5, 0, 1'b0, 1'b0);
    i_en = 1'b0;
    tick();
    checks++; if (data_m !== 8'hA5 || valid_m !== 1'b1) begin errors++; $display("FAIL ovf_first got=%h/%b exp=a5/1", data_m, valid_m); end
    send_word(8'h3C, 0, 1'b0, 1'b0);
    i_en = 1'b0;
    tick();
    checks++; if (data_m !== 8'hA5) begin errors++; $display("FAIL ovf_hold_data got=%h exp=a5", data_m); end
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL ovf_hold_valid got=%b exp=1", valid_m); end
    checks++; if (ovf_m !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_m); end
    i_ready = 1'b1;
    tick();
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL ovf_accept got=%b exp=0", valid_m); end
    checks++; if (ovf_m !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_m); end
    i_ready = 1'b0;
  endtask

  task automatic test_accept_on_complete();
    do_reset();
    i_ready = 1'b0;
    send_word(8'h11, 0, 1'b0, 1'b0);
    i_en = 1'b0;
    tick();
    checks++; if (data_m !== 8'h11) begin errors++; $display("FAIL aoc_first got=%h exp=11", data_m); end
    send_word(8'h22, 0, 1'b0, 1'b1);
    i_en = 1'b0;
    i_ready = 1'b0;
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL aoc_valid got=%b exp=1", valid_m); end
    checks++; if (data_m !== 8'h22) begin errors++; $display("FAIL aoc_data got=%h exp=22", data_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL aoc_ovf got=%b exp=0", ovf_m); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic premature;
    int   n_pre;
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_en = 1'b1; i_d = 1'b0; tick();
    end
    i_en = 1'b0;
    checks++; if (busy_m !== 1'b1 || st_m !== 2'd1) begin errors++; $display("FAIL mid_busy got=%b/%0d exp=1/1", busy_m, st_m); end
    i_rst = 1'b1;
    tick();
    checks++; if (busy_m !== 1'b0 || st_m !== 2'd0) begin errors++; $display("FAIL mid_rst_busy got=%b/%0d exp=0/0", busy_m, st_m); end
    i_rst = 1'b0;
    premature = 1'b0;
`ifdef SER2PAR_PARITY_EN
    n_pre = DW;
`else
    n_pre = DW - 1;
`endif
    for (int i = 0; i < n_pre; i++) begin
      i_en = 1'b1; i_d = 1'b1; tick();
      if (valid_m !== 1'b0) premature = 1'b1;
    end
`ifdef SER2PAR_PARITY_EN
    i_d = 1'b0;
`else
    i_d = 1'b1;
`endif
    tick();
    i_en = 1'b0;
    checks++; if (premature !== 1'b0) begin errors++; $display("FAIL mid_premature got=%b exp=0", premature); end
    checks++; if (valid_m !== 1'b1 || data_m !== 8'hFF) begin errors++; $display("FAIL mid_word got=%h/%b exp=ff/1", data_m, valid_m); end
    tick();
  endtask

  task automatic test_gaps();
    do_reset();
    i_ready = 1'b1;
    send_word(8'h6C, 10, 1'b0, 1'b0);
    i_en = 1'b0;
    checks++; if (valid_m !== 1'b1 || data_m !== 8'h6C) begin errors++; $display("FAIL gap_msb got=%h/%b exp=6c/1", data_m, valid_m); end
    checks++; if (data_l !== 8'h36) begin errors++; $display("FAIL gap_lsb got=%h exp=36", data_l); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_ready = 1'b1;
    send_word(8'hC3, 0, 1'b0, 1'b0);
    checks++; if (valid_m !== 1'b1 || data_m !== 8'hC3) begin errors++; $display("FAIL b2b_first got=%h/%b exp=c3/1", data_m, valid_m); end
    send_word(8'h5E, 0, 1'b0, 1'b0);
    i_en = 1'b0;
    checks++; if (valid_m !== 1'b1 || data_m !== 8'h5E) begin errors++; $display("FAIL b2b_second got=%h/%b exp=5e/1", data_m, valid_m); end
    checks++; if (data_l !== 8'h7A) begin errors++; $display("FAIL b2b_lsb got=%h exp=7a", data_l); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", ovf_m); end
    tick();
  endtask

`ifdef SER2PAR_PARITY_EN
  task automatic test_parity();
    do_reset();
    i_ready = 1'b1;
    send_word(8'h03, 0, 1'b0, 1'b0);
    i_en = 1'b0;
    checks++; if (perr_m !== 1'b0 || data_m !== 8'h03) begin errors++; $display("FAIL par_good got=%b/%h exp=0/03", perr_m, data_m); end
    tick();
    send_word(8'h03, 0, 1'b1, 1'b0);
    i_en = 1'b0;
    checks++; if (perr_m !== 1'b1) begin errors++; $display("FAIL par_bad got=%b exp=1", perr_m); end
    i_ready = 1'b0;
    send_word(8'h03, 0, 1'b0, 1'b0);
    i_en = 1'b0;
    checks++; if (perr_m !== 1'b1 || ovf_m !== 1'b1) begin errors++; $display("FAIL par_drop got=%b/%b exp=1/1", perr_m, ovf_m); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_bit_order();
    test_overflow();
    test_accept_on_complete();
    test_reset_mid_word();
    test_gaps();
    test_back_to_back();
`ifdef SER2PAR_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
